da_engine: RTL
==============

Name: da_engine

Overview:
- Bit-serial distributed-arithmetic (DA) MAC engine for the FIR datapath.
- Consumes the DA control strobes issued by the filter's Control FSM (start_DA, reset_DA, with resetn_DA wired to resetn).
- Holds the N_TAPS coefficients loaded during the coefficient-load phase.
- Latches the parallel tap vector from the sample FIFO and produces one filter output per frame of X_W+1 cycles.

Parameters:
- N_TAPS, 4, number of taps and coefficient registers; LUT has 2^N_TAPS entries.
- X_W, 8, signed two's-complement sample width; also the number of bit-serial cycles.
- C_W, 8, signed coefficient width.
- SHIFT, 7, right shift applied before rounding (DA_SAT_EN only).
- OUT_W, 10, saturated output width (DA_SAT_EN only).

Ports:
- clk  in  1  clock, all logic on posedge.
- resetn  in  1  synchronous active-low reset; top level drives it from resetn_DA.
- reset_DA  in  1  soft clear, active high.
- start_DA  in  1  level; run frames while high.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(N_TAPS)  coefficient index.
- coef_data  in  C_W  signed coefficient value.
- taps  in  N_TAPS*X_W  FIFO tap vector; tap k is bits [k*X_W +: X_W].
- sample_req  out  1  high during LOAD; FIFO may advance.
- busy  out  1  high when the state is not IDLE.
- y  out  FULL_W, where FULL_W = C_W+X_W+clog2(N_TAPS) (OUT_W if DA_SAT_EN)  filter result.
- y_valid  out  1  one-cycle pulse when y updates.

Behaviour:
- Reset (resetn=0 at a posedge):
  - state=IDLE; all coefficient registers = 0; accumulator = 0; bit counter = 0.
  - y=0, y_valid=0, sample_req=0, busy=0.
- States: IDLE, LOAD, ACC. sample_req=(state==LOAD); busy=(state!=IDLE).
- reset_DA=1 has priority over start_DA in every state:
  - Next state is IDLE; accumulator and counter are cleared; y_valid=0.
  - y and the coefficients are retained.
- IDLE:
  - coef_we=1 writes coef[coef_addr] <= coef_data. Writes are accepted only in IDLE, including while reset_DA=1; coef_we in LOAD/ACC is ignored.
  - start_DA=1 and reset_DA=0 -> LOAD.
- LOAD (1 cycle):
  - The tap vector is captured into N_TAPS shift registers at the closing edge.
  - acc <= 0, bit <= 0, next state ACC.
- ACC (X_W cycles, bit b = 0..X_W-1):
  - LUT address a[k] = bit b of tap register k.
  - L = sign-extended sum of coef[k] over all k with a[k]=1. L is computed combinationally, C_W+clog2(N_TAPS) bits wide.
  - For b < X_W-1: acc <= acc + (L << b). For b = X_W-1: acc <= acc - (L << (X_W-1)).
  - Arithmetic is full precision: acc is FULL_W bits and signed; no overflow is possible.
  - On the edge that ends b=X_W-1: y <= final acc value, y_valid <= 1 for one cycle. Next state is LOAD if start_DA=1, else IDLE.
- Timing:
  - Frame period is X_W+1 = 9 cycles.
  - y_valid occurs X_W edges after the tap-capture edge and coincides with the next LOAD cycle.
  - Back-to-back frames have no gap.
- start_DA falling mid-frame: the current frame completes and y_valid is produced, then the engine returns to IDLE.
- Taps change outside LOAD: no effect.
- Simultaneous coef_we and start_DA in IDLE: the write is committed; the new frame uses the new coefficient.
- resetn=0 mid-frame: full reset at that edge and no y_valid.

Optional Feature:
- Macro: DA_SAT_EN.
- Defined:
  - y is OUT_W bits: y = sat_OUT_W((acc + 2^(SHIFT-1)) >>> SHIFT), i.e. round-half-up.
  - Saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Latency is unchanged: the round/saturate is combinational into the y register.
- Undefined: y is the full FULL_W-bit accumulator; SHIFT and OUT_W are unused.

Test Plan:
- Default params:
  - Load coef = [1,2,3,4], taps all = 1, pulse start_DA -> sample_req high 1 cycle, y_valid 9 cycles after LOAD, y = 10.
  - coef0=127, others 0, tap0=-128 -> y = -16256.
  - All coefs = -128, all taps = -128 -> y = +65536 with no overflow (FULL_W=18).
  - start_DA held 30 cycles with taps constant at 1 and coefs [1,2,3,4] -> y_valid at cycles 9, 18, 27 relative to first LOAD, y=10 each. Dropping start_DA mid-frame still yields that frame's pulse.
  - reset_DA asserted at ACC bit 4 -> no y_valid; y keeps its prior value; IDLE the next cycle. coef_we during ACC -> coefficient is unchanged, which a following frame confirms.
- DA_SAT_EN:
  - The 65536 case -> y = 511 (saturated).
  - Coefs [1,2,3,4], taps 1 -> y = (10+64)>>>7 = 0.
  - coef0=127, tap0=-128 -> y = -127.

Source files
------------

// File: rtl/da_engine.sv
// da_engine: bit-serial distributed-arithmetic FIR MAC, one output per X_W+1 cycle frame.
// Define DA_SAT_EN to round and saturate y to OUT_W bits; otherwise y is the full accumulator.
module da_engine #(
    parameter int N_TAPS = 4,
    parameter int X_W    = 8,
    parameter int C_W    = 8,
    parameter int SHIFT  = 7,
    parameter int OUT_W  = 10,
    localparam int A_W    = $clog2(N_TAPS),
    localparam int FULL_W = C_W + X_W + A_W,
`ifdef DA_SAT_EN
    localparam int Y_W    = OUT_W
`else
    localparam int Y_W    = FULL_W
`endif
) (
    input  logic                    clk_i,
    input  logic                    resetn_i,
    input  logic                    reset_DA_i,
    input  logic                    start_DA_i,
    input  logic                    coef_we_i,
    input  logic [A_W-1:0]          coef_addr_i,
    input  logic [C_W-1:0]          coef_data_i,
    input  logic [N_TAPS*X_W-1:0]   taps_i,
    output logic                    sample_req_o,
    output logic                    busy_o,
    output logic [Y_W-1:0]          y_o,
    output logic                    y_valid_o
);
    localparam int L_W   = C_W + A_W;
    localparam int CNT_W = $clog2(X_W + 1);

    typedef enum logic [1:0] {IDLE, LOAD, ACC} state_t;

    state_t             state_q;
    logic [C_W-1:0]     coef_q [N_TAPS];
    logic [X_W-1:0]     tap_q  [N_TAPS];
    logic [FULL_W-1:0]  acc_q, acc_d, term;
    logic [CNT_W-1:0]   cnt_q;
    logic [L_W-1:0]     lut;
    logic [Y_W-1:0]     y_q, y_d;
    logic               y_valid_q, last;

    assign last = cnt_q == CNT_W'(X_W - 1);

    // Tap registers shift right each ACC cycle, so bit 0 always addresses the current sample bit.
    always_comb begin
        lut = '0;
        for (int k = 0; k < N_TAPS; k++)
            lut = lut + (tap_q[k][0] ? {{A_W{coef_q[k][C_W-1]}}, coef_q[k]} : L_W'(0));
        term  = {{X_W{lut[L_W-1]}}, lut} << cnt_q;
        acc_d = last ? acc_q - term : acc_q + term;
    end

`ifdef DA_SAT_EN
    localparam logic signed [FULL_W:0] HALF = (FULL_W+1)'(2 ** (SHIFT - 1));
    localparam logic signed [FULL_W:0] MAXV = (FULL_W+1)'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [FULL_W:0] MINV = (FULL_W+1)'(-(2 ** (OUT_W - 1)));
    logic signed [FULL_W:0] sum, rnd;
    always_comb begin
        sum = $signed({acc_d[FULL_W-1], acc_d}) + HALF;
        rnd = sum >>> SHIFT;
        y_d = rnd > MAXV ? MAXV[OUT_W-1:0] : rnd < MINV ? MINV[OUT_W-1:0] : rnd[OUT_W-1:0];
    end
`else
    assign y_d = acc_d;
`endif

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            for (int k = 0; k < N_TAPS; k++) begin
                coef_q[k] <= '0;
                tap_q[k]  <= '0;
            end
        end else begin
            y_valid_q <= 1'b0;
            if (state_q == IDLE && coef_we_i)
                coef_q[coef_addr_i] <= coef_data_i;
            if (reset_DA_i) begin
                state_q <= IDLE;
                acc_q   <= '0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: state_q <= start_DA_i ? LOAD : IDLE;
                    LOAD: begin
                        for (int k = 0; k < N_TAPS; k++)
                            tap_q[k] <= taps_i[k*X_W +: X_W];
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= ACC;
                    end
                    ACC: begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 1'b1;
                        for (int k = 0; k < N_TAPS; k++)
                            tap_q[k] <= tap_q[k] >> 1;
                        if (last) begin
                            y_q       <= y_d;
                            y_valid_q <= 1'b1;
                            state_q   <= start_DA_i ? LOAD : IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign sample_req_o = state_q == LOAD;
    assign busy_o       = state_q != IDLE;
    assign y_o          = y_q;
    assign y_valid_o    = y_valid_q;
endmodule
